bcd_scan_display: RTL and testbench

//  Downstream consumer of the cascaded decimal up/down counter digits: takes

---
 rtl/bcd_scan_display.sv | 133 +++++++++++++
 tb/tb_bcd_scan_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Time-multiplexed common-anode 7-segment driver for NDIG packed BCD digits.
// Scans one digit per prescaler tick and takes one snapshot of the digits per frame.
module bcd_scan_display #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic                clk,
  input  logic                s_n,
  input  logic                ce,
  input  logic [4*NDIG-1:0]   dat,
  input  logic [NDIG-1:0]     dp_in,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [2:0]          slot
);

  localparam int              CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [2:0]      SLOT_MAX = 3'(NDIG - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        slot_q, slot_d;
  logic [4*NDIG-1:0] snap_dat_q, snap_dat_d;
  logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              tick;
  logic              all_zero;
  logic [NDIG-1:0]   lz;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    tick       = ce && (cnt_q == CNT_MAX);
    cnt_d      = cnt_q;
    slot_d     = slot_q;
    snap_dat_d = snap_dat_q;
    snap_dp_d  = snap_dp_q;
    an_d       = an_q;
    seg_d      = seg_q;
    dp_d       = dp_q;
    all_zero   = 1'b1;
    lz         = '0;
    cur_digit  = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;

    if (ce) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    if (tick) begin
      slot_d = (slot_q == SLOT_MAX) ? 3'd0 : slot_q + 3'd1;
      if (slot_q == SLOT_MAX) begin
        snap_dat_d = dat;
        snap_dp_d  = dp_in;
      end
    end

    // lz[i] is set when every snapshot digit from the top down to i is zero.
    for (int i = NDIG - 1; i >= 0; i--) begin
      all_zero = all_zero & (snap_dat_d[i*4 +: 4] == 4'd0);
      lz[i]    = all_zero;
    end

    for (int i = 0; i < NDIG; i++) begin
      if (slot_d == 3'(i)) begin
        cur_digit = snap_dat_d[i*4 +: 4];
        cur_dp    = snap_dp_d[i];
        cur_blank = (BLANK_LZ != 0) && (i != 0) && lz[i];
      end
    end

    // Outputs are loaded on the tick edge so they move together with slot.
    if (tick) begin
      for (int i = 0; i < NDIG; i++) begin
        an_d[i] = (slot_d != 3'(i));
      end
      seg_d = cur_blank ? 7'h7F : bcd_to_seg(cur_digit);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or negedge s_n) begin
    if (!s_n) begin
      cnt_q      <= '0;
      slot_q     <= SLOT_MAX;
      snap_dat_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      snap_dat_q <= snap_dat_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign slot = slot_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: table of per-frame vectors plus
// hand-written sequences for snapshot tearing, ce freeze and async reset.
module tb_bcd_scan_display;

  logic        clk;
  logic        s_n;
  logic        ce;
  logic [15:0] dat;
  logic [3:0]  dp_in;
  logic [3:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [2:0]  slot, slot_nb;

  int total;
  int bad;

  typedef struct packed {
    logic [15:0]      dat;
    logic [3:0]       dp_in;
    logic [3:0][6:0]  seg_b;
    logic [3:0][6:0]  seg_nb;
  } vec_t;

  vec_t vecs [10];

  bcd_scan_display #(.NDIG(4), .SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .s_n(s_n), .ce(ce), .dat(dat), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .slot(slot)
  );

  bcd_scan_display #(.NDIG(4), .SCAN_DIV(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .s_n(s_n), .ce(ce), .dat(dat), .dp_in(dp_in),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb), .slot(slot_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_slot();
    repeat (4) step();
  endtask

  // Checks both instances against one slot's expected display.
  task automatic check_slot(input string tag, input logic [2:0] exp_slot,
                            input logic [6:0] exp_seg, input logic [6:0] exp_seg_nb,
                            input logic exp_dp);
    logic [3:0] exp_an;
    exp_an = 4'hF ^ (4'b0001 << exp_slot);
    check_output({tag, " slot"},   {5'b0, slot},   {5'b0, exp_slot});
    check_output({tag, " an"},     {4'b0, an},     {4'b0, exp_an});
    check_output({tag, " seg"},    {1'b0, seg},    {1'b0, exp_seg});
    check_output({tag, " dp"},     {7'b0, dp},     {7'b0, exp_dp});
    check_output({tag, " an_nb"},  {4'b0, an_nb},  {4'b0, exp_an});
    check_output({tag, " seg_nb"}, {1'b0, seg_nb}, {1'b0, exp_seg_nb});
  endtask

  task automatic check_dark(input string tag, input logic [2:0] exp_slot);
    check_output({tag, " an"},      {4'b0, an},     8'h0F);
    check_output({tag, " seg"},     {1'b0, seg},    8'h7F);
    check_output({tag, " dp"},      {7'b0, dp},     8'h01);
    check_output({tag, " slot"},    {5'b0, slot},   {5'b0, exp_slot});
    check_output({tag, " an_nb"},   {4'b0, an_nb},  8'h0F);
    check_output({tag, " slot_nb"}, {5'b0, slot_nb},{5'b0, exp_slot});
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p);
    dat   = d;
    dp_in = p;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    s_n   = 1'b0;
    ce    = 1'b0;
    dat   = '0;
    dp_in = '0;

    // seg arrays written as {slot3, slot2, slot1, slot0}
    vecs[0] = '{16'h1234, 4'b0000, {7'h79,7'h24,7'h30,7'h19}, {7'h79,7'h24,7'h30,7'h19}};
    vecs[1] = '{16'h0007, 4'b0000, {7'h7F,7'h7F,7'h7F,7'h78}, {7'h40,7'h40,7'h40,7'h78}};
    vecs[2] = '{16'h0000, 4'b0000, {7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40}};
    vecs[3] = '{16'h00A5, 4'b0010, {7'h7F,7'h7F,7'h3F,7'h12}, {7'h40,7'h40,7'h3F,7'h12}};
    vecs[4] = '{16'h0199, 4'b0000, {7'h7F,7'h79,7'h10,7'h10}, {7'h40,7'h79,7'h10,7'h10}};
    vecs[5] = '{16'h1000, 4'b1001, {7'h79,7'h40,7'h40,7'h40}, {7'h79,7'h40,7'h40,7'h40}};
    vecs[6] = '{16'h9086, 4'b0100, {7'h10,7'h40,7'h00,7'h02}, {7'h10,7'h40,7'h00,7'h02}};
    vecs[7] = '{16'hF0B0, 4'b0000, {7'h3F,7'h40,7'h3F,7'h40}, {7'h3F,7'h40,7'h3F,7'h40}};
    vecs[8] = '{16'h0C00, 4'b0000, {7'h7F,7'h3F,7'h40,7'h40}, {7'h40,7'h3F,7'h40,7'h40}};
    vecs[9] = '{16'h0050, 4'b1111, {7'h7F,7'h7F,7'h12,7'h40}, {7'h40,7'h40,7'h12,7'h40}};

    step();
    step();
    check_dark("reset", 3'd3);

    s_n = 1'b1;
    ce  = 1'b1;

    // Each vector is applied while slot 3 is shown, so the next tick snapshots it.
    for (int v = 0; v < 10; v++) begin
      apply_stimulus(vecs[v].dat, vecs[v].dp_in);
      for (int s = 0; s < 4; s++) begin
        run_slot();
        check_slot($sformatf("vec%0d s%0d", v, s), 3'(s), vecs[v].seg_b[s],
                   vecs[v].seg_nb[s], ~vecs[v].dp_in[s]);
      end
    end

    // Input changes mid-frame must not reach the current frame.
    apply_stimulus(16'h0199, 4'b0000);
    run_slot(); check_slot("tear s0", 3'd0, 7'h10, 7'h10, 1'b1);
    run_slot(); check_slot("tear s1", 3'd1, 7'h10, 7'h10, 1'b1);
    run_slot(); check_slot("tear s2", 3'd2, 7'h79, 7'h79, 1'b1);
    step(); step();
    apply_stimulus(16'h8200, 4'b1111);
    step(); step();
    check_slot("tear s3", 3'd3, 7'h7F, 7'h40, 1'b1);
    run_slot(); check_slot("new s0", 3'd0, 7'h40, 7'h40, 1'b0);
    run_slot(); check_slot("new s1", 3'd1, 7'h40, 7'h40, 1'b0);
    run_slot(); check_slot("new s2", 3'd2, 7'h24, 7'h24, 1'b0);
    run_slot(); check_slot("new s3", 3'd3, 7'h00, 7'h00, 1'b0);

    // ce low mid-slot freezes everything; resuming finishes the same slot.
    apply_stimulus(16'h1234, 4'b0000);
    run_slot(); check_slot("frz s0", 3'd0, 7'h19, 7'h19, 1'b1);
    run_slot(); check_slot("frz s1", 3'd1, 7'h30, 7'h30, 1'b1);
    step(); step();
    ce = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check_slot($sformatf("frz hold%0d", k), 3'd1, 7'h30, 7'h30, 1'b1);
    end
    ce = 1'b1;
    step(); check_slot("frz resume1", 3'd1, 7'h30, 7'h30, 1'b1);
    step(); check_slot("frz resume2", 3'd2, 7'h24, 7'h24, 1'b1);
    run_slot(); check_slot("frz s3", 3'd3, 7'h79, 7'h79, 1'b1);

    // Async reset in the middle of slot 2 blanks the display immediately.
    apply_stimulus(16'h1234, 4'b0100);
    run_slot(); check_slot("rst s0", 3'd0, 7'h19, 7'h19, 1'b1);
    run_slot(); check_slot("rst s1", 3'd1, 7'h30, 7'h30, 1'b1);
    run_slot(); check_slot("rst s2", 3'd2, 7'h24, 7'h24, 1'b0);
    step();
    #2;
    s_n = 1'b0;
    #1;
    check_dark("rst async", 3'd3);
    step();
    check_dark("rst held", 3'd3);
    s_n = 1'b1;
    step(); step(); step();
    check_dark("rst count", 3'd3);
    step();
    check_slot("rst first tick", 3'd0, 7'h19, 7'h19, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
